// File: rtl/wb_trace_serializer.sv
// wb_trace_serializer: serializes dual-slot WB commits in program order onto the single-commit debug trace port.
// Optional build macro WB_TRACE_SKIP_NOWB_EN: push only slots that write the register file.
module wb_trace_serializer #(
    parameter int DEPTH = 8,
    parameter int PTR_W = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i1,
    input  logic [31:0] pc_i1,
    input  logic        we_i1,
    input  logic [4:0]  waddr_i1,
    input  logic [31:0] wdata_i1,
    input  logic        valid_i2,
    input  logic [31:0] pc_i2,
    input  logic        we_i2,
    input  logic [4:0]  waddr_i2,
    input  logic [31:0] wdata_i2,
    input  logic        trace_ready,
    output logic        trace_valid,
    output logic [31:0] debug_wb_pc,
    output logic [3:0]  debug_wb_rf_wen,
    output logic [4:0]  debug_wb_rf_wnum,
    output logic [31:0] debug_wb_rf_wdata,
    output logic        stall_req,
    output logic        overflow
);
    logic [69:0]      mem [DEPTH];
    logic [69:0]      head;
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [PTR_W:0]   count;
    logic [PTR_W+1:0] free;
    logic             elig1, elig2, pop, push1, push2;
`ifdef WB_TRACE_SKIP_NOWB_EN
    assign elig1 = valid_i1 && we_i1;
    assign elig2 = valid_i2 && we_i2;
`else
    assign elig1 = valid_i1;
    assign elig2 = valid_i2;
`endif
    assign head      = mem[rd_ptr];
    assign stall_req = count >= (PTR_W+1)'(DEPTH - 4);
    // Space left after this cycle's pop decides which slots fit; i2 is dropped first.
    always_comb begin
        pop   = (count != '0) && trace_ready;
        free  = (PTR_W+2)'(DEPTH) - (PTR_W+2)'(count) + (PTR_W+2)'(pop);
        push1 = elig1 && (free != '0);
        push2 = elig2 && (elig1 ? free >= (PTR_W+2)'(2) : free != '0);
    end
    // FIFO storage; i1 always lands before i2.
    always_ff @(posedge clk) begin
        if (push1) mem[wr_ptr] <= {pc_i1, we_i1, waddr_i1, wdata_i1};
        if (push2) mem[push1 ? wr_ptr + PTR_W'(1) : wr_ptr] <= {pc_i2, we_i2, waddr_i2, wdata_i2};
    end
    // Pointers, occupancy and the sticky drop flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push1) + PTR_W'(push2);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + (PTR_W+1)'(push1) + (PTR_W+1)'(push2) - (PTR_W+1)'(pop);
            if ((elig1 && !push1) || (elig2 && !push2)) overflow <= 1'b1;
        end
    end
    // Output registers: the popped head is presented for exactly one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trace_valid       <= 1'b0;
            debug_wb_pc       <= '0;
            debug_wb_rf_wen   <= '0;
            debug_wb_rf_wnum  <= '0;
            debug_wb_rf_wdata <= '0;
        end else begin
            trace_valid     <= pop;
            debug_wb_rf_wen <= pop ? {4{head[37]}} : 4'b0;
            if (pop) begin
                debug_wb_pc       <= head[69:38];
                debug_wb_rf_wnum  <= head[36:32];
                debug_wb_rf_wdata <= head[31:0];
            end
        end
    end
endmodule

// File: tb/tb_wb_trace_serializer.sv
// tb_wb_trace_serializer: scoreboard plus table-driven checks for wb_trace_serializer.
module tb_wb_trace_serializer;
    logic        clk = 0, rst = 1;
    logic        valid_i1 = 0, we_i1 = 0, valid_i2 = 0, we_i2 = 0, trace_ready = 0;
    logic [31:0] pc_i1 = 0, wdata_i1 = 0, pc_i2 = 0, wdata_i2 = 0;
    logic [4:0]  waddr_i1 = 0, waddr_i2 = 0;
    logic        trace_valid, stall_req, overflow;
    logic [31:0] debug_wb_pc, debug_wb_rf_wdata;
    logic [3:0]  debug_wb_rf_wen;
    logic [4:0]  debug_wb_rf_wnum;

    wb_trace_serializer #(.DEPTH(8), .PTR_W(3)) dut (
        .clk(clk), .rst(rst),
        .valid_i1(valid_i1), .pc_i1(pc_i1), .we_i1(we_i1), .waddr_i1(waddr_i1), .wdata_i1(wdata_i1),
        .valid_i2(valid_i2), .pc_i2(pc_i2), .we_i2(we_i2), .waddr_i2(waddr_i2), .wdata_i2(wdata_i2),
        .trace_ready(trace_ready), .trace_valid(trace_valid), .debug_wb_pc(debug_wb_pc),
        .debug_wb_rf_wen(debug_wb_rf_wen), .debug_wb_rf_wnum(debug_wb_rf_wnum),
        .debug_wb_rf_wdata(debug_wb_rf_wdata), .stall_req(stall_req), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ent_t;

    typedef struct {
        logic        v1;
        logic [31:0] pc1;
        logic        we1;
        logic        v2;
        logic [31:0] pc2;
        logic        we2;
        logic        rdy;
        logic        exp_ovf;
    } vec_t;

    ent_t        sbq[$];
    vec_t        tab[20];
    int          total = 0, bad = 0;
    int          mcount = 0;
    logic        movf = 0;
    logic [31:0] lpc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        sbq.delete();
        mcount = 0;
        movf = 0;
        lpc = 0;
    endtask

    task automatic cyc(input logic v1, input logic [31:0] pc1, input logic we1, input logic [4:0] wa1,
                       input logic [31:0] wd1, input logic v2, input logic [31:0] pc2, input logic we2,
                       input logic [4:0] wa2, input logic [31:0] wd2, input logic rdy);
        logic e1, e2, ev;
        int   free;
        ent_t exp;
        valid_i1 = v1; pc_i1 = pc1; we_i1 = we1; waddr_i1 = wa1; wdata_i1 = wd1;
        valid_i2 = v2; pc_i2 = pc2; we_i2 = we2; waddr_i2 = wa2; wdata_i2 = wd2;
        trace_ready = rdy;
`ifdef WB_TRACE_SKIP_NOWB_EN
        e1 = v1 && we1;
        e2 = v2 && we2;
`else
        e1 = v1;
        e2 = v2;
`endif
        chk("stall_req", {31'b0, stall_req}, {31'b0, mcount >= 4});
        ev = (mcount > 0) && rdy;
        free = 8 - mcount + (ev ? 1 : 0);
        exp = '{default: '0};
        if (ev) exp = sbq.pop_front();
        if (e1) begin
            if (free > 0) begin sbq.push_back('{pc1, we1, wa1, wd1}); free--; mcount++; end
            else movf = 1;
        end
        if (e2) begin
            if (free > 0) begin sbq.push_back('{pc2, we2, wa2, wd2}); free--; mcount++; end
            else movf = 1;
        end
        if (ev) mcount--;
        @(posedge clk);
        #1;
        chk("trace_valid", {31'b0, trace_valid}, {31'b0, ev});
        chk("overflow", {31'b0, overflow}, {31'b0, movf});
        if (ev) begin
            chk("pc", debug_wb_pc, exp.pc);
            chk("wen", {28'b0, debug_wb_rf_wen}, {28'b0, {4{exp.we}}});
            chk("wnum", {27'b0, debug_wb_rf_wnum}, {27'b0, exp.wa});
            chk("wdata", debug_wb_rf_wdata, exp.wd);
            lpc = exp.pc;
        end else begin
            chk("idle_wen", {28'b0, debug_wb_rf_wen}, 32'h0);
            chk("pc_hold", debug_wb_pc, lpc);
        end
    endtask

    task automatic idle(input logic rdy);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, rdy);
    endtask

    task automatic check_reset_outputs();
        chk("rst_valid", {31'b0, trace_valid}, 32'h0);
        chk("rst_pc", debug_wb_pc, 32'h0);
        chk("rst_wen", {28'b0, debug_wb_rf_wen}, 32'h0);
        chk("rst_wnum", {27'b0, debug_wb_rf_wnum}, 32'h0);
        chk("rst_wdata", debug_wb_rf_wdata, 32'h0);
        chk("rst_ovf", {31'b0, overflow}, 32'h0);
        chk("rst_stall", {31'b0, stall_req}, 32'h0);
    endtask

    initial begin
        for (int i = 0; i < 20; i++) begin
            tab[i].v1      = (i % 4) != 3;
            tab[i].pc1     = 32'h2000 + 32'(i * 8);
            tab[i].we1     = (i % 3) != 0;
            tab[i].v2      = (i % 4) == 1;
            tab[i].pc2     = 32'h2004 + 32'(i * 8);
            tab[i].we2     = 1'b1;
            tab[i].rdy     = (i % 4) != 2;
            tab[i].exp_ovf = 1'b0;
        end
        #12;
        check_reset_outputs();
        #10 rst = 0;
        model_reset();

        // single i1 commit, visible two edges after push
        cyc(1, 32'hBFC00000, 1, 5'd8, 32'h1234, 0, 0, 0, 0, 0, 1);
        repeat (3) idle(1);

        // dual push drained in program order
        cyc(1, 32'h100, 1, 5'd1, 32'hA1, 1, 32'h104, 1, 5'd2, 32'hA2, 1);
        repeat (3) idle(1);

        // fill with trace blocked; one in-flight dual after stall_req, then idle
        begin
            logic st;
            for (int i = 0; i < 6; i++) begin
                st = stall_req;
                cyc(1, 32'h400 + 32'(i * 8), 1, 5'(i), 32'(i), 1, 32'h404 + 32'(i * 8), 1, 5'(i + 16), 32'(i + 100), 0);
                if (st) break;
            end
        end
        chk("no_ovf_after_stall", {31'b0, overflow}, 32'h0);
        repeat (9) idle(1);

        // fill to 7, then dual push drops i2 and sets the sticky flag
        for (int i = 0; i < 7; i++) cyc(1, 32'h800 + 32'(i * 4), 1, 5'(i + 3), 32'(i * 3), 0, 0, 0, 0, 0, 0);
        cyc(1, 32'h900, 1, 5'd9, 32'h9, 1, 32'h904, 1, 5'd10, 32'hA, 0);
        chk("ovf_set", {31'b0, overflow}, 32'h1);
        repeat (2) idle(0);
        repeat (9) idle(1);
        chk("ovf_held", {31'b0, overflow}, 32'h1);

        // asynchronous reset with entries buffered
        cyc(1, 32'hC00, 1, 5'd4, 32'h44, 1, 32'hC04, 1, 5'd5, 32'h55, 0);
        idle(1);
        #2 rst = 1;
        #1;
        check_reset_outputs();
        @(posedge clk);
        #3 rst = 0;
        model_reset();
        repeat (2) idle(1);

        // table: wrap-around stream with trace_ready toggling
        for (int i = 0; i < 20; i++) begin
            cyc(tab[i].v1, tab[i].pc1, tab[i].we1, 5'(i), $urandom, tab[i].v2, tab[i].pc2, tab[i].we2, 5'(31 - i), $urandom, tab[i].rdy);
            chk("tab_ovf", {31'b0, overflow}, {31'b0, tab[i].exp_ovf});
        end
        repeat (10) idle(1);
        chk("sb_empty", 32'(sbq.size()), 32'h0);

        // non-writing i1 followed by writing i2
        cyc(1, 32'h300, 0, 5'd0, 32'h0, 1, 32'h304, 1, 5'd7, 32'h77, 1);
        repeat (3) idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/wb_trace_serializer.md
Name: wb_trace_serializer

Overview:
- Accepts up to two write-back commits per cycle from the dual-issue WB stage (slot i1 older than slot i2).
- Serializes them, in program order, onto the single-commit debug trace port (debug_wb_pc / rf_wen / rf_wnum / rf_wdata), one commit per cycle.
- Is a synthesizable replacement for clock-phase multiplexing of the two slots.
- Buffers commits in a small FIFO and requests a pipeline stall when the buffer nears full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, minimum 8.
- PTR_W, 3, pointer width, log2(DEPTH).

Ports:
- clk  input  1  core clock
- rst  input  1  reset, asynchronous, active-high
- valid_i1  input  1  slot i1 carries a retired instruction this cycle
- pc_i1  input  32  slot i1 PC
- we_i1  input  1  slot i1 register-file write enable
- waddr_i1  input  5  slot i1 destination register
- wdata_i1  input  32  slot i1 write data
- valid_i2, pc_i2, we_i2, waddr_i2, wdata_i2  input  1/32/1/5/32  same fields for slot i2
- trace_ready  input  1  trace consumer accepts one commit this cycle
- trace_valid  output  1  debug outputs carry a commit this cycle
- debug_wb_pc  output  32  committed PC
- debug_wb_rf_wen  output  4  {4{we}} of the committed entry
- debug_wb_rf_wnum  output  5  committed destination register
- debug_wb_rf_wdata  output  32  committed write data
- stall_req  output  1  to the stall controller; freezes the MEM->WB register
- overflow  output  1  sticky error flag; a commit was dropped

Behaviour:
- Reset (async, rst=1): pointers, count, overflow, trace_valid, and all debug outputs become 0. FIFO contents are don't-care.
- Entry format: {pc[31:0], we, waddr[4:0], wdata[31:0]}, 70 bits.
- Push eligibility: a slot is eligible when valid_x=1 (subject to the optional feature).
- Push order:
  - i1 is always written before i2.
  - Both eligible: i1 goes to wr_ptr, i2 to wr_ptr+1.
  - Only one eligible: it goes to wr_ptr.
  - wr_ptr advances by n_push (0..2), modulo DEPTH.
- Pop: when count>0 and trace_ready=1, the head entry moves into the output registers at the clock edge and rd_ptr advances by 1 modulo DEPTH.
  - count is the value registered at the start of the cycle.
- Output registers:
  - On a pop: trace_valid=1, debug_wb_rf_wen={4{we}}, and pc/wnum/wdata are loaded from the entry.
  - On no pop: trace_valid=0 and debug_wb_rf_wen=4'b0; pc/wnum/wdata hold their last values.
- Latency: no bypass. A commit pushed at edge N appears on the outputs after edge N+1 at the earliest.
- Simultaneous push and pop: both take effect. count_next = count + n_push - pop.
- Pop from empty: suppressed when count=0, regardless of trace_ready.
- stall_req: combinational, equals (count >= DEPTH-4).
  - The 4-entry margin covers the one in-flight unstalled cycle at two commits per cycle.
- Overflow:
  - If n_push exceeds the free space (DEPTH - count + pop), the entries that do not fit are dropped, youngest (i2) first.
  - overflow is set to 1 and stays set until reset.
  - Entries already in the FIFO are unaffected.
- Wrap-around: pointers are PTR_W bits and wrap naturally. count is PTR_W+1 bits, range 0..DEPTH.
- Reset mid-operation: all buffered commits are discarded immediately and the outputs go to 0 asynchronously.

Optional Feature:
- Macro: WB_TRACE_SKIP_NOWB_EN.
- Defined: a slot is eligible only when valid_x=1 and we_x=1. Non-writing retirements (branches, stores, hilo-only) are never pushed, and every trace_valid=1 cycle has debug_wb_rf_wen=4'hf.
- Undefined: every valid slot is pushed; non-writing commits appear with debug_wb_rf_wen=4'h0 and trace_valid=1.

Test Plan:
- Reset, then one cycle with i1 only (pc=0xBFC00000, we=1, waddr=8, wdata=0x1234), trace_ready=1 -> trace_valid=1 exactly once, 2 edges after the push, with pc=0xBFC00000, wen=4'hf, wnum=8, wdata=0x1234.
- Dual push (i1 pc=0x100 waddr=1; i2 pc=0x104 waddr=2), trace_ready=1 -> two consecutive output cycles, pc 0x100 then 0x104. count returns to 0 and trace_valid=0 on the next cycle.
- trace_ready=0 with dual pushes every cycle from empty, DEPTH=8 -> stall_req asserts once count>=4. No overflow occurs if the inputs go idle one cycle after stall_req. Draining afterwards yields all PCs in order.
- Force dual pushes while count=7 with trace_ready=0 -> i1 stored, i2 dropped, overflow=1 and held until rst.
- Wrap: stream 20 alternating single and dual pushes with trace_ready toggling -> output PC sequence equals input order, with no gaps or duplicates across pointer wrap.
- i1 with we=0, i2 with we=1 -> macro undefined: two outputs, wen 0x0 then 0xf. Macro defined: one output, wen 0xf.
